wb_arbiter: RTL and testbench

- Writeback-stage arbiter that drives the register file write port (WE3/AD3/WD3).
- Merges two sources:
  - the single-cycle pipeline writeback (ALU or load result), which always has priority;
  - a late-result stream from multi-cycle units (divider, slow loads), which is queued in a small FIFO.
- Keeps a busy scoreboard of registers awaiting late results, so hazard logic can stall readers.

---
 rtl/wb_arbiter.sv | 155 +++++++++++++++
 tb/tb_wb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback has priority, late results queue in a FIFO.
// Latency: pipeline writes are combinational; late results appear the cycle after acceptance at the earliest.
// Backpressure: late_ready drops while the FIFO is full; the pipeline is never stalled by this block.
//
// Optional feature: define WB_ARBITER_BYPASS_EN to let a late result write through in its
// acceptance cycle when the FIFO is empty and the pipeline is idle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pipe_we/pipe_rd/pipe_wd         single-cycle pipeline writeback
//   issue_valid/issue_rd            multi-cycle dispatch, marks destination busy
//   late_valid/late_ready/late_rd/late_wd  late-result stream (valid/ready)
//   we3/ad3/wd3                     register file write port
//   busy                            per-register pending-late-write scoreboard
//   wb_err                          sticky protocol-violation flag
module wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pipe_we,
    input  logic [ADDRESS_WIDTH-1:0]    pipe_rd,
    input  logic [DATA_WIDTH-1:0]       pipe_wd,
    input  logic                        issue_valid,
    input  logic [ADDRESS_WIDTH-1:0]    issue_rd,
    input  logic                        late_valid,
    output logic                        late_ready,
    input  logic [ADDRESS_WIDTH-1:0]    late_rd,
    input  logic [DATA_WIDTH-1:0]       late_wd,
    output logic                        we3,
    output logic [ADDRESS_WIDTH-1:0]    ad3,
    output logic [DATA_WIDTH-1:0]       wd3,
    output logic [2**ADDRESS_WIDTH-1:0] busy,
    output logic                        wb_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NREGS = 2**ADDRESS_WIDTH;

    logic [ADDRESS_WIDTH-1:0] fifo_rd [DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_wd [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [CNT_W-1:0]         count;

    logic                     pipe_act;
    logic                     empty;
    logic                     full;
    logic                     bypass;
    logic                     push;
    logic                     pop;
    logic                     commit;
    logic [ADDRESS_WIDTH-1:0] commit_rd;
    logic [ADDRESS_WIDTH-1:0] head_rd;
    logic [DATA_WIDTH-1:0]    head_wd;
    logic [NREGS-1:0]         busy_next;
    logic                     err_now;

    // A pipeline write to r0 is a no-op, so it leaves the port free for the FIFO.
    assign pipe_act   = pipe_we && (pipe_rd != '0);
    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign late_ready = !full;
    assign head_rd    = fifo_rd[rd_ptr];
    assign head_wd    = fifo_wd[rd_ptr];

    // Gating with rst_n keeps the write port quiet while reset is held, whatever the inputs do.
    assign pop = rst_n && !pipe_act && !empty;

`ifdef WB_ARBITER_BYPASS_EN
    assign bypass = rst_n && late_valid && empty && !pipe_act;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed result is consumed by the write port and never enters the FIFO.
    assign push      = late_valid && late_ready && !bypass;
    assign commit    = pop || bypass;
    assign commit_rd = pop ? head_rd : late_rd;

    always_comb begin
        we3 = 1'b0;
        ad3 = '0;
        wd3 = '0;
        if (rst_n && pipe_act) begin
            we3 = 1'b1;
            ad3 = pipe_rd;
            wd3 = pipe_wd;
        end else if (pop) begin
            we3 = (head_rd != '0);
            ad3 = head_rd;
            wd3 = head_wd;
        end else if (bypass) begin
            we3 = (late_rd != '0);
            ad3 = late_rd;
            wd3 = late_wd;
        end
    end

    // Clear first, then set, so a same-cycle issue to the retiring register stays busy.
    always_comb begin
        busy_next = busy;
        if (commit && (commit_rd != '0))
            busy_next[commit_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_next[issue_rd] = 1'b1;
    end

    // r0 is never tracked, so a late write to r0 is not treated as a spurious retire.
    always_comb begin
        err_now = 1'b0;
        if (issue_valid && (issue_rd != '0) && busy[issue_rd])
            err_now = 1'b1;
        if (pipe_act && busy[pipe_rd])
            err_now = 1'b1;
        if (commit && (commit_rd != '0) && !busy[commit_rd])
            err_now = 1'b1;
    end

    // Payload storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr] <= late_rd;
            fifo_wd[wr_ptr] <= late_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            busy   <= '0;
            wb_err <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer wrap is plain binary overflow.
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            busy <= busy_next;
            if (err_now)
                wb_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pipe_we = 1'b0;
    logic [AW-1:0] pipe_rd = '0;
    logic [DW-1:0] pipe_wd = '0;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rd = '0;
    logic          late_valid = 1'b0;
    logic          late_ready;
    logic [AW-1:0] late_rd = '0;
    logic [DW-1:0] late_wd = '0;
    logic          we3;
    logic [AW-1:0] ad3;
    logic [DW-1:0] wd3;
    logic [31:0]   busy;
    logic          wb_err;

    wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_wd(pipe_wd),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .late_valid(late_valid), .late_ready(late_ready),
        .late_rd(late_rd), .late_wd(late_wd),
        .we3(we3), .ad3(ad3), .wd3(wd3),
        .busy(busy), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    // Monitor: every write-port event is matched against the expected queue, including its cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (we3) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: got ad3=%0d wd3=%h at cycle %0d, required no write", ad3, wd3, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.ad != ad3 || e.wd != wd3) begin
                        n_err++;
                        $display("FAIL wr_data: got ad3=%0d wd3=%h cycle %0d, required ad3=%0d wd3=%h cycle %0d",
                                 ad3, wd3, cyc, e.ad, e.wd, e.cyc);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                n_checks++;
                n_err++;
                e = exp_q.pop_front();
                $display("FAIL wr_missing: got we3=0 at cycle %0d, required ad3=%0d wd3=%h", cyc, e.ad, e.wd);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        pipe_we = 1'b0; pipe_rd = '0; pipe_wd = '0;
        issue_valid = 1'b0; issue_rd = '0;
        late_valid = 1'b0; late_rd = '0; late_wd = '0;
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        exp_t e;
        e.cyc = cyc;
        e.ad = a;
        e.wd = d;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic pipe(input logic [AW-1:0] rd, input logic [DW-1:0] wd);
        pipe_we = 1'b1; pipe_rd = rd; pipe_wd = wd;
        exp_wr(rd, wd);
    endtask

    task automatic late(input logic [AW-1:0] rd, input logic [DW-1:0] wd);
        late_valid = 1'b1; late_rd = rd; late_wd = wd;
    endtask

    task automatic issue(input logic [AW-1:0] rd);
        issue_valid = 1'b1; issue_rd = rd;
    endtask

    initial begin
        idle();
        #1;
        chk("rst_we3", 64'(we3), 0);
        chk("rst_ad3", 64'(ad3), 0);
        chk("rst_wd3", 64'(wd3), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(late_ready), 1);
        chk("rst_err", 64'(wb_err), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pipeline priority over a queued late result
        step(); idle(); issue(5'd7);
        step(); idle(); pipe(5'd5, 32'hDEADBEEF); late(5'd7, 32'h11);
        settle(); chk("busy7_set", 64'(busy[7]), 1);
        step(); idle(); pipe(5'd5, 32'hDEADBEEF);
        step(); idle(); pipe(5'd5, 32'hDEADBEEF);
        step(); idle(); exp_wr(5'd7, 32'h11);
        settle(); chk("busy7_held", 64'(busy[7]), 1);
        step(); idle();
        settle(); chk("busy7_clr", 64'(busy), 0);

        // Fill to full, then drain in order
        for (int i = 1; i <= 4; i++) begin
            step(); idle(); issue(AW'(i));
        end
        for (int i = 1; i <= 4; i++) begin
            step(); idle(); pipe(5'd6, 32'hA0 + 32'(i)); late(AW'(i), 32'h100 + 32'(i));
            settle(); chk("ready_fill", 64'(late_ready), 1);
        end
        chk("busy_r1_r4", 64'(busy), 64'h1E);
        step(); idle(); pipe(5'd6, 32'hAF);
        settle(); chk("ready_full", 64'(late_ready), 0);
        for (int i = 1; i <= 4; i++) begin
            step(); idle(); exp_wr(AW'(i), 32'h100 + 32'(i));
            settle(); chk("ready_drain", 64'(late_ready), (i == 1) ? 64'd0 : 64'd1);
        end
        step(); idle();
        settle(); chk("busy_drained", 64'(busy), 0);

        // Push/pop at count=2 across the pointer wrap
        for (int i = 0; i < 2; i++) begin
            step(); idle(); pipe(5'd6, 32'hB0 + 32'(i)); issue(AW'(10 + i)); late(AW'(10 + i), 32'h20A + 32'(i));
        end
        for (int i = 2; i < 5; i++) begin
            step(); idle(); issue(AW'(10 + i)); late(AW'(10 + i), 32'h20A + 32'(i));
            exp_wr(AW'(8 + i), 32'h208 + 32'(i));
            settle(); chk("ready_pushpop", 64'(late_ready), 1);
        end
        for (int i = 3; i < 5; i++) begin
            step(); idle(); exp_wr(AW'(10 + i), 32'h20A + 32'(i));
        end
        step(); idle();
        settle(); chk("busy_wrap_clr", 64'(busy), 0);

        // Double issue sets sticky error
        step(); idle(); issue(5'd9);
        step(); idle(); issue(5'd9);
        settle(); chk("err_before", 64'(wb_err), 0);
        step(); idle();
        settle(); chk("err_dbl_issue", 64'(wb_err), 1);
        step(); step();
        settle(); chk("err_sticky", 64'(wb_err), 1);

        // Full FIFO and busy r9, then reset asserted mid-cycle
        for (int i = 0; i < 4; i++) begin
            step(); idle(); pipe(5'd6, 32'hC0 + 32'(i)); late(AW'(20 + i), 32'(i));
        end
        step(); idle();
        settle(); chk("full_before_rst", 64'(late_ready), 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_ready", 64'(late_ready), 1);
        chk("midrst_busy", 64'(busy), 0);
        chk("midrst_we3", 64'(we3), 0);
        chk("midrst_err", 64'(wb_err), 0);
        step(); rst_n = 1'b1;

        // Pipeline write to a busy register
        step(); idle(); issue(5'd9);
        step(); idle(); pipe(5'd9, 32'h99);
        settle(); chk("waw_before", 64'(wb_err), 0);
        step(); idle();
        settle(); chk("err_waw", 64'(wb_err), 1);
        #1 rst_n = 1'b0;
        step(); rst_n = 1'b1;

        // Late result to r0, then r3 (write-through when bypass is built in)
        step(); idle(); issue(5'd3);
        step(); idle(); late(5'd0, 32'h77);
        settle(); chk("busy3_set", 64'(busy), 64'h8);
        step(); idle();
        step(); idle();
        settle(); chk("busy_r0_unchanged", 64'(busy), 64'h8);
        chk("ready_after_r0", 64'(late_ready), 1);
        step(); idle(); late(5'd3, 32'h55);
`ifdef WB_ARBITER_BYPASS_EN
        exp_wr(5'd3, 32'h55);
        settle();
        chk("bypass_we3", 64'(we3), 1);
        chk("bypass_ad3", 64'(ad3), 3);
        chk("bypass_wd3", 64'(wd3), 64'h55);
`else
        settle(); chk("no_same_cycle", 64'(we3), 0);
        step(); idle(); exp_wr(5'd3, 32'h55);
`endif
        step(); idle();
        settle(); chk("busy3_clr", 64'(busy), 0);

        repeat (3) step();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
